// File: rtl/bss_scanner_if.sv
// Bus bundle for the seven-segment scan controller: display data and load
// request flowing in, decoded digit-drive signals flowing out.
interface bss_scanner_if;
  logic [15:0] value_i;
  logic [3:0]  digit_en_i;
  logic [3:0]  dp_i;
  logic        load_i;
  logic [3:0]  bin_o;
  logic [3:0]  anode_o;
  logic        dp_o;
  logic        frame_o;

  // Producer of display data (testbench or host logic).
  modport master (
    output value_i, digit_en_i, dp_i, load_i,
    input  bin_o, anode_o, dp_o, frame_o
  );

  // The scanner itself.
  modport slave (
    input  value_i, digit_en_i, dp_i, load_i,
    output bin_o, anode_o, dp_o, frame_o
  );
endinterface

// File: rtl/bss_scanner.sv
// Time-multiplexed scan controller for a four-digit seven-segment display.
// Rotates through the digits with a blanking interval at the start of every
// slot, and double-buffers the display data so new values only take effect
// at frame boundaries.
module bss_scanner #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  bss_scanner_if.slave bus
);

  localparam int CW = $clog2(REFRESH_DIV);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;

  logic [15:0]   r_actValue;
  logic [3:0]    r_actEn;
  logic [3:0]    r_actDp;

  logic [15:0]   r_pendValue;
  logic [3:0]    r_pendEn;
  logic [3:0]    r_pendDp;
  logic          r_pend;

  logic          w_wrap;
  logic          w_boundary;
  logic          w_blank;
  logic [3:0]    w_anode;
  logic          w_dp;

  assign w_wrap     = (r_cnt == CW'(REFRESH_DIV - 1));
  assign w_boundary = w_wrap && (r_idx == 2'd3);
  assign w_blank    = (r_cnt < CW'(BLANK_CYCLES));

  // Slot counter and digit index: the digit advances whenever the slot wraps.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else if (w_wrap) begin
      r_cnt <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Shadow/active data registers: loads park in the pending copy and are
  // promoted at the frame boundary; a load in the boundary cycle bypasses
  // the pending copy and goes straight to active.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_actValue  <= 16'h0000;
      r_actEn     <= 4'h0;
      r_actDp     <= 4'h0;
      r_pendValue <= 16'h0000;
      r_pendEn    <= 4'h0;
      r_pendDp    <= 4'h0;
      r_pend      <= 1'b0;
    end else if (w_boundary) begin
      if (bus.load_i) begin
        r_actValue <= bus.value_i;
        r_actEn    <= bus.digit_en_i;
        r_actDp    <= bus.dp_i;
      end else if (r_pend) begin
        r_actValue <= r_pendValue;
        r_actEn    <= r_pendEn;
        r_actDp    <= r_pendDp;
      end
      r_pend <= 1'b0;
    end else if (bus.load_i) begin
      r_pendValue <= bus.value_i;
      r_pendEn    <= bus.digit_en_i;
      r_pendDp    <= bus.dp_i;
      r_pend      <= 1'b1;
    end
  end

  // Digit drive decode from registered state only; anode and dot stay off
  // during the blanking part of each slot.
  always_comb begin
    w_anode = 4'b1111;
    w_dp    = 1'b1;
    if (!w_blank) begin
      w_anode[r_idx] = ~r_actEn[r_idx];
      w_dp           = ~r_actDp[r_idx];
    end
  end

  assign bus.bin_o   = r_actValue[{r_idx, 2'b00} +: 4];
  assign bus.anode_o = w_anode;
  assign bus.dp_o    = w_dp;
  assign bus.frame_o = (r_idx == 2'd0) && (r_cnt == '0);

endmodule

// File: tb/tb_bss_scanner.sv
// Self-checking bench for bss_scanner with an 8-cycle slot and 2 blanking
// cycles. A frame-position reference model predicts every output each cycle.
module tb_bss_scanner;

  localparam int RDIV  = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 4 * RDIV;

  logic clk_i;
  logic rst_i;

  bss_scanner_if bus ();

  bss_scanner #(
    .REFRESH_DIV (RDIV),
    .BLANK_CYCLES(BLANK)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus.slave)
  );

  // Free-running 10 ns clock.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference model: position within the frame plus active/pending data.
  int          mPhase = 0;
  logic [15:0] mActV  = 16'h0;
  logic [3:0]  mActEn = 4'h0;
  logic [3:0]  mActDp = 4'h0;
  logic [15:0] mPendV = 16'h0;
  logic [3:0]  mPendEn = 4'h0;
  logic [3:0]  mPendDp = 4'h0;
  bit          mPend  = 1'b0;
  bit          mValid = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // One clock of stimulus: drive inputs, advance the model across the edge,
  // then compare every output against the model.
  task automatic applyStimulus(input bit rst, input bit load, input logic [15:0] v,
                               input logic [3:0] en, input logic [3:0] dp);
    int idx, cnt;
    logic [3:0] expAnode;
    logic       expDp;
    rst_i          = rst;
    bus.load_i     = load;
    bus.value_i    = v;
    bus.digit_en_i = en;
    bus.dp_i       = dp;
    @(posedge clk_i);
    if (rst) begin
      mPhase = 0;
      mActV = 0; mActEn = 0; mActDp = 0;
      mPendV = 0; mPendEn = 0; mPendDp = 0;
      mPend = 0;
      mValid = 1'b1;
    end else begin
      if (mPhase == FRAME - 1) begin
        if (load) begin
          mActV = v; mActEn = en; mActDp = dp;
        end else if (mPend) begin
          mActV = mPendV; mActEn = mPendEn; mActDp = mPendDp;
        end
        mPend = 0;
      end else if (load) begin
        mPendV = v; mPendEn = en; mPendDp = dp; mPend = 1;
      end
      mPhase = (mPhase + 1) % FRAME;
    end
    #1;
    if (mValid) begin
      idx = mPhase / RDIV;
      cnt = mPhase % RDIV;
      if (cnt < BLANK) begin
        expAnode = 4'b1111;
        expDp    = 1'b1;
      end else begin
        expAnode = 4'b1111 ^ (4'(mActEn[idx]) << idx);
        expDp    = ~mActDp[idx];
      end
      checkOutput("bin",   32'(bus.bin_o),   32'((mActV >> (4 * idx)) & 16'hF));
      checkOutput("anode", 32'(bus.anode_o), 32'(expAnode));
      checkOutput("dp",    32'(bus.dp_o),    32'(expDp));
      checkOutput("frame", 32'(bus.frame_o), 32'(mPhase == 0));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 16'h0, 4'h0, 4'h0);
  endtask

  // Idle until the model reaches frame position p (bounded by one frame).
  task automatic runUntil(input int p);
    for (int g = 0; g < FRAME && mPhase != p; g++) applyStimulus(0, 0, 16'h0, 4'h0, 4'h0);
    checkOutput("runUntil", 32'(mPhase), 32'(p));
  endtask

  initial begin
    rst_i          = 1'b1;
    bus.load_i     = 1'b0;
    bus.value_i    = 16'h0;
    bus.digit_en_i = 4'h0;
    bus.dp_i       = 4'h0;

    // Reset for three cycles; the load alongside reset must be ignored.
    applyStimulus(1, 0, 16'h0, 4'h0, 4'h0);
    applyStimulus(1, 1, 16'hFFFF, 4'hF, 4'hF);
    applyStimulus(1, 0, 16'h0, 4'h0, 4'h0);
    checkOutput("rstAnode", 32'(bus.anode_o), 32'hF);
    checkOutput("rstFrame", 32'(bus.frame_o), 32'h1);
    idle(70);

    // Scan pattern.
    applyStimulus(0, 1, 16'hA5C3, 4'b1111, 4'b0100);
    runUntil(0);
    idle(FRAME);

    // Enable masking.
    applyStimulus(0, 1, 16'h9876, 4'b0101, 4'b0000);
    runUntil(0);
    idle(FRAME);

    // Tear-free commit: 1111 becomes active, then 2222 is overwritten by 3333.
    applyStimulus(0, 1, 16'h1111, 4'hF, 4'h0);
    runUntil(0);
    runUntil(RDIV + 3);
    applyStimulus(0, 1, 16'h2222, 4'hF, 4'h0);
    runUntil(2 * RDIV + 3);
    checkOutput("tear1s", 32'(bus.bin_o), 32'h1);
    applyStimulus(0, 1, 16'h3333, 4'hF, 4'h0);
    runUntil(0);
    checkOutput("tear3s", 32'(bus.bin_o), 32'h3);
    idle(FRAME);

    // Boundary-cycle load goes straight to active.
    runUntil(FRAME - 1);
    applyStimulus(0, 1, 16'hBEEF, 4'hF, 4'h2);
    checkOutput("bdryFrame", 32'(bus.frame_o), 32'h1);
    checkOutput("bdryBin",   32'(bus.bin_o),   32'hF);
    idle(FRAME + 8);

    // Reset mid-operation with a load pending.
    runUntil(2 * RDIV);
    applyStimulus(0, 1, 16'h4321, 4'hF, 4'hF);
    runUntil(2 * RDIV + 5);
    applyStimulus(1, 0, 16'h0, 4'h0, 4'h0);
    checkOutput("midRstBin", 32'(bus.bin_o), 32'h0);
    idle(3 * FRAME);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      applyStimulus(($urandom % 250) == 0, ($urandom % 12) == 0,
                    16'($urandom), 4'($urandom), 4'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bss_scanner.md
# bss_scanner

Time-multiplexed scan controller for the Basys3 four-digit seven-segment display. It holds a 16-bit display value plus per-digit enable and decimal-point masks, and rotates through the four digits. For each digit it drives the active-low anode, the active-low decimal point, and the 4-bit nibble that feeds the downstream hex-to-cathode decoder (`bss_decoder`). A blanking interval at each digit change suppresses ghosting, and a shadow register applies new values only at frame boundaries so digits never tear.

## Interface
- `REFRESH_DIV`, default 100000: clock cycles per digit slot (1 kHz per digit at 100 MHz). Legal range: 2 to 2^24.
- `BLANK_CYCLES`, default 1000: cycles at the start of each slot with all anodes off. Legal range: 1 to `REFRESH_DIV`-1.
- `clk_i` input, 1 bit: system clock.
- `rst_i` input, 1 bit: reset, synchronous and active-high.
- `value_i` input, 16 bits: four hex nibbles. Digit 0 is `value_i[3:0]`, the rightmost digit, with anode 0.
- `digit_en_i` input, 4 bits: per-digit enable. 1 means the digit is lit.
- `dp_i` input, 4 bits: per-digit decimal point. 1 means the dot is lit.
- `load_i` input, 1 bit: single-cycle request to capture `value_i`, `digit_en_i` and `dp_i`.
- `bin_o` output, 4 bits: nibble of the current digit, sent to the decoder.
- `anode_o` output, 4 bits: active-low anode selects.
- `dp_o` output, 1 bit: active-low decimal-point cathode.
- `frame_o` output, 1 bit: high for exactly one cycle at the start of each frame.

## Operation
- **State:**
  - Slot counter `cnt`, range 0..`REFRESH_DIV`-1.
  - Digit index `idx`, range 0..3.
  - Active registers: value, en, dp.
  - Pending registers: value, en, dp, plus a `pend` flag.
- **Slot phases:**
  - BLANK while `cnt` < `BLANK_CYCLES`.
  - DRIVE while `cnt` >= `BLANK_CYCLES`.
- **Slot advance:**
  - `cnt` increments every cycle.
  - At `REFRESH_DIV`-1, `cnt` wraps to 0 and `idx` increments modulo 4 (3 wraps to 0).
- **Load:**
  - When `load_i`=1, the inputs are written to the pending registers and `pend` is set.
  - A later load before commit overwrites the earlier one; the last load wins.
- **Commit:**
  - A frame boundary is the cycle where `cnt`=`REFRESH_DIV`-1 and `idx`=3.
  - On the edge ending that cycle, active takes pending if `pend`=1, and `pend` is cleared.
  - If `load_i`=1 in the boundary cycle itself, the `value_i`/`digit_en_i`/`dp_i` presented that cycle go straight to active and `pend` ends 0.
- **Outputs** are decoded from registered state only; there is no combinational path from any input to any output.
  - `bin_o` = active value nibble `idx`. It holds through the whole slot, BLANK included, so the decoder settles before the anode turns on.
  - `anode_o`:
    - BLANK: 4'b1111.
    - DRIVE: bit `idx` = ~active_en[`idx`]; all other bits 1.
  - `dp_o`:
    - BLANK: 1.
    - DRIVE: ~active_dp[`idx`].
  - `frame_o` = 1 exactly when `idx`=0 and `cnt`=0.
- **Reset** (`rst_i` high at a rising edge) sets `cnt`=0, `idx`=0, all active and pending registers to 0, and `pend`=0.
  - While in reset and on the first cycle after it: `bin_o`=4'h0, `anode_o`=4'b1111, `dp_o`=1, `frame_o`=1.
  - The display stays dark until the first load commits, because active en resets to 0.
- **Reset mid-operation** abandons the current slot and any pending load. Scanning restarts at digit 0, BLANK phase.
- `load_i` asserted in the same cycle as `rst_i` is ignored.

## Timing
- Frame period: 4×`REFRESH_DIV` cycles. Each digit's DRIVE window is `REFRESH_DIV`-`BLANK_CYCLES` cycles.
- Anode change to output: `anode_o`, `dp_o`, `bin_o` and `frame_o` change on the same edge as the state they decode, so there is zero added latency relative to `cnt`/`idx`.
- Load-to-display latency:
  - Minimum: 1 cycle, when the load lands in the boundary cycle.
  - Maximum: 4×`REFRESH_DIV` cycles, when the load lands one cycle after a boundary.
- `frame_o` cycles coincide with the first cycle that uses newly committed values.
- Anodes are never active in two slots back-to-back; there are at least `BLANK_CYCLES` cycles of 4'b1111 between any two DRIVE windows.

## Test plan
All scenarios use `REFRESH_DIV`=8 and `BLANK_CYCLES`=2.
- **Reset values:** assert `rst_i` for 3 cycles, then release.
  - During reset and in the first free-running cycle: `anode_o`=1111, `dp_o`=1, `bin_o`=0, `frame_o`=1.
  - `frame_o` repeats every 32 cycles.
- **Scan pattern:** pulse `load_i` with `value_i`=16'hA5C3, `digit_en_i`=1111, `dp_i`=0100. In the frame after commit:
  - Digit 0: `bin_o`=3, `anode_o`=1110 for `cnt` 2..7.
  - Digit 2: `bin_o`=5, `anode_o`=1011, `dp_o`=0.
  - Digit 3: `bin_o`=A.
  - Every `cnt` 0..1: `anode_o`=1111.
- **Enable masking:** load `digit_en_i`=0101.
  - `anode_o` drives 1110 in slot 0 and 1011 in slot 2.
  - Slots 1 and 3 stay 1111 throughout while `bin_o` still cycles.
- **Tear-free commit:** load 16'h1111, then mid-frame (`idx`=1) load 16'h2222, then (`idx`=2) load 16'h3333.
  - The current frame shows only 1s.
  - The next frame shows only 3s.
  - The value 2 never appears.
- **Boundary-cycle load:** pulse `load_i` with 16'hBEEF exactly when `idx`=3 and `cnt`=7.
  - Next cycle: `frame_o`=1 and `bin_o`=F.
  - `pend` ends 0, so no further change occurs at the following boundary.
- **Reset mid-operation:** assert `rst_i` at `idx`=2, `cnt`=5, with a load pending.
  - Outputs return to reset values.
  - The display stays dark for whole frames with no `load_i`.
